uart_reg_cmd_ctrl: RTL and testbench

Command sequencer for the processor-less SoC. It turns the UART receive byte stream into register-bus transactions and returns status and read data through the UART transmit byte path. It sits between the UART core's byte-level RX/TX handshakes and the internal peripheral register bus (PWM, GPIO, SPI), and acts as the sole bus master.

---
 rtl/uart_reg_cmd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_uart_reg_cmd_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_cmd_ctrl.sv
// UART command sequencer: parses 'W'/'R' byte commands from the UART RX path,
// runs one register-bus transaction as sole master, and streams the ACK/NAK
// status (plus read data) back out of the UART TX path.
module uart_reg_cmd_ctrl #(
    parameter int unsigned ByteTimeout = 20000,
    parameter int unsigned BusTimeout  = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [7:0]  bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        busy_o,
    output logic        rx_drop_o
);

    // One counter serves both timeouts; they are never active at the same time.
    localparam int unsigned CntMax = (ByteTimeout > BusTimeout) ? ByteTimeout : BusTimeout;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] ByteLim = CntW'(ByteTimeout - 1);
    localparam logic [CntW-1:0] BusLim  = CntW'(BusTimeout - 1);

    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] OpRead  = 8'h52;
    localparam logic [7:0] Ack     = 8'h06;
    localparam logic [7:0] Nak     = 8'h15;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_TX} state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [2:0]      idx_q, idx_d;    // wdata byte index in WDATA, response byte index in TX
    logic [2:0]      last_q, last_d;  // index of the final response byte
    logic [7:0]      resp_q, resp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            drop_q, drop_d;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            resp_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state: command parse, bus handshake with timeout, response streaming
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        last_d  = last_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        drop_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == OpWrite || rx_data_i == OpRead) begin
                        we_d    = (rx_data_i == OpWrite);
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end else begin
                        resp_d  = Nak;
                        last_d  = 3'd0;
                        idx_d   = 3'd0;
                        state_d = S_TX;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = rx_data_i;
                    cnt_d  = '0;
                    idx_d  = 3'd0;
                    if (we_q) begin
                        state_d = S_WDATA;
                    end else begin
                        req_d   = 1'b1;  // request goes out the cycle after the last byte
                        state_d = S_BUS;
                    end
                end else if (cnt_q == ByteLim) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WDATA: begin
                if (rx_valid_i) begin
                    wdata_d[8*idx_q[1:0] +: 8] = rx_data_i;
                    cnt_d = '0;
                    if (idx_q == 3'd3) begin
                        req_d   = 1'b1;
                        state_d = S_BUS;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (cnt_q == ByteLim) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BUS: begin
                drop_d = rx_valid_i;
                if (req_q && bus_gnt_i) req_d = 1'b0;
                if (bus_rvalid_i) begin
                    req_d   = 1'b0;
                    idx_d   = 3'd0;
                    state_d = S_TX;
                    if (bus_err_i) begin
                        resp_d = Nak;
                        last_d = 3'd0;
                    end else begin
                        resp_d = Ack;
                        last_d = we_q ? 3'd0 : 3'd4;
                        if (!we_q) rdata_d = bus_rdata_i;
                    end
                end else if (cnt_q == BusLim) begin
                    // Abort: late gnt/rvalid are ignored once we leave BUS.
                    req_d   = 1'b0;
                    resp_d  = Nak;
                    last_d  = 3'd0;
                    idx_d   = 3'd0;
                    state_d = S_TX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TX: begin
                drop_d = rx_valid_i;
                if (tx_ready_i) begin
                    if (idx_q == last_q) state_d = S_IDLE;
                    else                 idx_d   = idx_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response byte select: status first, then read data little-endian
    always_comb begin
        tx_data_o = 8'h00;
        if (state_q == S_TX) begin
            case (idx_q)
                3'd0:    tx_data_o = resp_q;
                3'd1:    tx_data_o = rdata_q[7:0];
                3'd2:    tx_data_o = rdata_q[15:8];
                3'd3:    tx_data_o = rdata_q[23:16];
                3'd4:    tx_data_o = rdata_q[31:24];
                default: tx_data_o = 8'h00;
            endcase
        end
    end

    assign tx_valid_o  = (state_q == S_TX);
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign rx_drop_o   = drop_q;

endmodule

// File: tb/tb_uart_reg_cmd_ctrl.sv
// Directed bench for uart_reg_cmd_ctrl: drives at the falling edge, samples there too.
module tb_uart_reg_cmd_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b0;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [7:0]  bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_err_i = 1'b0;
    logic        busy_o;
    logic        rx_drop_o;

    int n_assert = 0;
    int n_fail   = 0;

    uart_reg_cmd_ctrl #(.ByteTimeout(100), .BusTimeout(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .busy_o(busy_o), .rx_drop_o(rx_drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        tick();
        rx_valid_i = 1'b0;
        rx_data_i  = '0;
    endtask

    // Grant one cycle after req is seen, rvalid two cycles after grant.
    task automatic bus_serve(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic err);
        chk("req_latency", bus_req_o, 1'b1);
        chk("bus_we", bus_we_o, we);
        chk("bus_addr", bus_addr_o, addr);
        if (we) chk("bus_wdata", bus_wdata_o, wdata);
        tick();
        chk("req_held", bus_req_o, 1'b1);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk("req_drop_after_gnt", bus_req_o, 1'b0);
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rdata;
        bus_err_i    = err;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        bus_err_i    = 1'b0;
    endtask

    task automatic get_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!tx_valid_o && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, tx_valid_o, 1'b1);
        chk(tag, tx_data_o, exp);
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_txv"}, tx_valid_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        tick();
        chk("rst_txv", tx_valid_o, 1'b0);
        chk("rst_txd", tx_data_o, 8'h00);
        chk("rst_req", bus_req_o, 1'b0);
        chk("rst_we", bus_we_o, 1'b0);
        chk("rst_addr", bus_addr_o, 8'h00);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_drop", rx_drop_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Write
        send(8'h57); send(8'h10); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        bus_serve(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        get_tx("wr_ack", 8'h06);
        chk_idle("wr_done");

        // Read with a 3-cycle stall on byte 2
        send(8'h52); send(8'h24);
        bus_serve(1'b0, 8'h24, 32'h0, 32'h12345678, 1'b0);
        get_tx("rd_b0", 8'h06);
        get_tx("rd_b1", 8'h78);
        for (int i = 0; i < 3; i++) begin
            chk("rd_stall_valid", tx_valid_o, 1'b1);
            chk("rd_stall_data", tx_data_o, 8'h56);
            tick();
        end
        get_tx("rd_b2", 8'h56);
        get_tx("rd_b3", 8'h34);
        get_tx("rd_b4", 8'h12);
        chk_idle("rd_done");

        // Bus error
        send(8'h52); send(8'h30);
        bus_serve(1'b0, 8'h30, 32'h0, 32'hFFFFFFFF, 1'b1);
        get_tx("err_nak", 8'h15);
        chk_idle("err_done");

        // Bus timeout: req must stay high exactly 64 cycles
        send(8'h52); send(8'h31);
        n = 0;
        while (bus_req_o && n < 200) begin
            n++;
            tick();
        end
        chk("to_req_cycles", n, 64);
        chk("to_tx_valid", tx_valid_o, 1'b1);
        bus_gnt_i = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i = 32'hAABBCCDD;
        tick();
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i = '0;
        chk("to_late_req", bus_req_o, 1'b0);
        get_tx("to_nak", 8'h15);
        chk_idle("to_done");

        // Bad opcode, with a dropped byte during its response
        send(8'h41);
        chk("bad_txv", tx_valid_o, 1'b1);
        send(8'h52);
        chk("drop_pulse", rx_drop_o, 1'b1);
        chk("drop_state_data", tx_data_o, 8'h15);
        tick();
        chk("drop_pulse_end", rx_drop_o, 1'b0);
        get_tx("bad_nak", 8'h15);
        chk_idle("bad_done");

        // Byte timeout mid-write
        send(8'h57); send(8'h10); send(8'hAA);
        repeat (99) tick();
        chk("bto_still_busy", busy_o, 1'b1);
        tick();
        chk("bto_idle", busy_o, 1'b0);
        chk("bto_no_req", bus_req_o, 1'b0);
        chk("bto_no_tx", tx_valid_o, 1'b0);
        send(8'h52); send(8'h10);
        bus_serve(1'b0, 8'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        get_tx("bto_b0", 8'h06);
        get_tx("bto_b1", 8'h0D);
        get_tx("bto_b2", 8'hF0);
        get_tx("bto_b3", 8'hFE);
        get_tx("bto_b4", 8'hCA);
        chk_idle("bto_done");

        // Asynchronous reset while requesting the bus
        send(8'h52); send(8'h44);
        chk("ar_req_before", bus_req_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_req", bus_req_o, 1'b0);
        chk("ar_busy", busy_o, 1'b0);
        chk("ar_addr", bus_addr_o, 8'h00);
        chk("ar_txv", tx_valid_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();
        send(8'h52); send(8'h48);
        bus_serve(1'b0, 8'h48, 32'h0, 32'h0BADCAFE, 1'b0);
        get_tx("ar_b0", 8'h06);
        get_tx("ar_b1", 8'hFE);
        get_tx("ar_b2", 8'hCA);
        get_tx("ar_b3", 8'hAD);
        get_tx("ar_b4", 8'h0B);
        chk_idle("ar_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
